// File: rtl/di_issue_ctrl.sv
// Second-slot (I2) dual-issue scheduler: gates I2 ID->EX advance alongside the primary issue,
// stalls I2 on PI load-use hazards, flushes on kill/branch and throttles PAIR re-entry.
module di_issue_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int COOLDOWN_CYC = 2,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  di_en_cfg,
   input  logic                  cnt_clr,
   input  logic                  pi_id_ready,
   input  logic                  pi_ex_ready,
   input  logic                  pi_wb_ready,
   input  logic                  pi_data_misaligned,
   input  logic                  pi_branch_taken_ex,
   input  logic                  pi_load_stall,
   input  logic                  pi_unusal_state_prevent_di,
   input  logic                  pi_unusal_state_kill_di,
   input  logic                  pi_halt_id,
   input  logic                  pi_load_in_ex,
   input  logic [REG_ADDR_W-1:0] pi_load_rd_ex,
   input  logic                  i2_instr_valid_id,
   input  logic                  i2_rs1_used,
   input  logic                  i2_rs2_used,
   input  logic [REG_ADDR_W-1:0] i2_rs1_addr_id,
   input  logic [REG_ADDR_W-1:0] i2_rs2_addr_id,
   output logic                  i2_issue_id,
   output logic                  i2_kill,
   output logic                  i2_load_stall_cond,
   output logic                  di_active,
   output logic [1:0]            di_state,
   output logic [CNT_W-1:0]      di_pair_cnt
);

   localparam int CD_W = (COOLDOWN_CYC < 1) ? 1 : $clog2(COOLDOWN_CYC + 1);
   localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN_CYC);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PAIR  = 2'd1,
      ST_STALL = 2'd2,
      ST_DRAIN = 2'd3
   } di_state_e;

   di_state_e        state_r, state_nxt_s;
   logic [CD_W-1:0]  cd_cnt_r, cd_cnt_nxt_s;
   logic [CNT_W-1:0] pair_cnt_r;
   logic             hazard_s, kev_s, ok_s;
   logic             rs1_hit_s, rs2_hit_s;
   logic             issue_s, kill_s, stall_cond_s;
   logic             unused_wb_ready_s;

   // WB readiness is a debug-only observation; it never affects scheduling.
   assign unused_wb_ready_s = pi_wb_ready;

   assign rs1_hit_s = i2_rs1_used & (i2_rs1_addr_id == pi_load_rd_ex);
   assign rs2_hit_s = i2_rs2_used & (i2_rs2_addr_id == pi_load_rd_ex);
   // x0 is never a real load destination, so it cannot create a hazard.
   assign hazard_s  = i2_instr_valid_id & pi_load_in_ex &
                      (pi_load_rd_ex != {REG_ADDR_W{1'b0}}) & (rs1_hit_s | rs2_hit_s);
   assign kev_s     = pi_unusal_state_kill_di | pi_branch_taken_ex;
   assign ok_s      = di_en_cfg & ~pi_unusal_state_prevent_di & ~pi_halt_id;

   // Next-state, cooldown and combinational slot outputs; kill beats prevent beats hazard.
   always_comb begin
      state_nxt_s  = state_r;
      cd_cnt_nxt_s = cd_cnt_r;
      issue_s      = 1'b0;
      kill_s       = 1'b0;
      stall_cond_s = 1'b0;
      case (state_r)
         ST_OFF: begin
            if (ok_s) begin
               if (cd_cnt_r == {CD_W{1'b0}}) begin
                  state_nxt_s  = ST_PAIR;
                  cd_cnt_nxt_s = {CD_W{1'b0}};
               end else begin
                  cd_cnt_nxt_s = cd_cnt_r - {{(CD_W-1){1'b0}}, 1'b1};
               end
            end else begin
               cd_cnt_nxt_s = CD_RELOAD;
            end
         end
         ST_PAIR: begin
            issue_s      = i2_instr_valid_id & pi_id_ready & ~hazard_s &
                           ~pi_load_stall & ~kev_s & ok_s;
            stall_cond_s = hazard_s;
            kill_s       = kev_s;
            if (kev_s) begin
               state_nxt_s = ST_DRAIN;
            end else if (!ok_s) begin
               state_nxt_s  = ST_OFF;
               cd_cnt_nxt_s = CD_RELOAD;
            end else if (hazard_s) begin
               state_nxt_s = ST_STALL;
            end else begin
               state_nxt_s = ST_PAIR;
            end
         end
         ST_STALL: begin
            stall_cond_s = 1'b1;
            kill_s       = kev_s;
            if (kev_s) begin
               state_nxt_s = ST_DRAIN;
            end else if (pi_ex_ready && !pi_data_misaligned) begin
               if (ok_s) begin
                  state_nxt_s = ST_PAIR;
               end else begin
                  state_nxt_s  = ST_OFF;
                  cd_cnt_nxt_s = CD_RELOAD;
               end
            end else begin
               state_nxt_s = ST_STALL;
            end
         end
         ST_DRAIN: begin
            kill_s = 1'b1;
            if (pi_id_ready && !kev_s) begin
               state_nxt_s  = ST_OFF;
               cd_cnt_nxt_s = CD_RELOAD;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s  = ST_OFF;
            cd_cnt_nxt_s = CD_RELOAD;
         end
      endcase
   end

   // State and cooldown registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_OFF;
         cd_cnt_r <= CD_RELOAD;
      end else begin
         state_r  <= state_nxt_s;
         cd_cnt_r <= cd_cnt_nxt_s;
      end
   end

   // Saturating paired-issue counter; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         pair_cnt_r <= {CNT_W{1'b0}};
      end else if (issue_s && (pair_cnt_r != {CNT_W{1'b1}})) begin
         pair_cnt_r <= pair_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         pair_cnt_r <= pair_cnt_r;
      end
   end

   assign i2_issue_id        = issue_s;
   assign i2_kill            = kill_s;
   assign i2_load_stall_cond = stall_cond_s;
   assign di_state           = state_r;
   assign di_active          = (state_r == ST_PAIR) | (state_r == ST_STALL);
   assign di_pair_cnt        = pair_cnt_r;

endmodule
